// File: rtl/ram_burst_reader.sv
// ram_burst_reader
//   Read initiator for one port of a synchronous RAM with a 1-cycle registered
//   read and no read enable. Accepts a burst command (start address, word
//   count), issues sequential reads and delivers the words as a valid/ready
//   stream with full backpressure.
//
//   Ports
//     clk, rst              single clock, synchronous active-high reset
//     cmd_valid/cmd_ready   burst command handshake (cmd_ready = idle)
//     cmd_addr, cmd_len     first word address, word count (0 = no-op)
//     ram_addr              RAM read address (held when no read issues)
//     ram_wr, ram_din       RAM write port, tied off (read-only initiator)
//     ram_qout              RAM registered read data
//     m_data/m_valid/m_ready/m_last   output stream
//     busy                  command accepted, last word not yet accepted
//     done                  one-cycle pulse after the last word is accepted
//
//   The output side is a 2-entry buffer plus a bypass: when the buffer is
//   empty, the word arriving on ram_qout is presented directly, so data can
//   appear the cycle after the read is issued. A word that is presented but
//   not accepted is pushed into the buffer, which keeps m_data stable.
//   A read issues only while buffered words + the in-flight read stay within
//   the 2 entries (counting the word being accepted this cycle as freed).

module ram_burst_reader #(
  parameter int DW    = 8,
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS),
  parameter int LW    = $clog2(WORDS) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  output logic [AW-1:0] ram_addr,
  output logic          ram_wr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_qout,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t state, state_next;

  logic [AW-1:0] addr_q;      // address of the next read to issue
  logic [LW-1:0] remaining;   // reads still to issue
  logic          pend;        // a read was issued last cycle; ram_qout is ours
  logic          pend_last;   // ...and it is the final word of the burst
  logic [DW-1:0] buf_data [2];
  logic [1:0]    buf_last;
  logic [1:0]    count;       // buffered words, entry 0 is the head
  logic          done_q;

  logic          hs;
  logic          issue;
  logic          accept;
  logic          push;
  logic          pop;
  logic          wr_idx;
  logic [2:0]    occ;
  logic [2:0]    cap;
  logic          credit_ok;

  // Read-only port: write side tied off.
  assign ram_wr   = 1'b0;
  assign ram_din  = '0;
  assign ram_addr = addr_q;

  assign cmd_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign done      = done_q;

  // Stream head: buffer first, else the word arriving from the RAM.
  assign m_valid = (count != 2'd0) || pend;
  assign m_data  = (count != 2'd0) ? buf_data[0] : (pend ? ram_qout : '0);
  assign m_last  = (count != 2'd0) ? buf_last[0] : (pend && pend_last);
  assign hs      = m_valid && m_ready;

  // Credit: occupancy + in-flight must stay below 2 + (word leaving now).
  assign occ       = {1'b0, count} + {2'b00, pend};
  assign cap       = 3'd2 + {2'b00, hs};
  assign credit_ok = (occ < cap);

  // The in-flight word is stored unless it leaves through the bypass.
  assign pop    = hs && (count != 2'd0);
  assign push   = pend && !(hs && (count == 2'd0));
  // Slot the pushed word lands in, after any pop has shifted the buffer.
  assign wr_idx = pop ? (count == 2'd2) : (count == 2'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept = 1'b1;
          if (cmd_len != '0) state_next = ISSUE;
        end
      end
      ISSUE: begin
        if ((remaining != '0) && credit_ok) begin
          issue = 1'b1;
          if (remaining == LW'(1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        // The last word is the final one out, so its handshake means empty.
        if (hs && m_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      remaining <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      count     <= 2'd0;
      buf_last  <= 2'b00;
      done_q    <= 1'b0;
    end else begin
      done_q <= (accept && (cmd_len == '0)) || ((state == DRAIN) && hs && m_last);

      if (accept && (cmd_len != '0)) begin
        addr_q    <= cmd_addr;
        remaining <= cmd_len;
      end else if (issue) begin
        remaining <= remaining - LW'(1);
        // After the final read the address stays on the last location read.
        if (remaining != LW'(1)) addr_q <= addr_q + AW'(1);
      end

      pend      <= issue;
      pend_last <= issue && (remaining == LW'(1));

      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop)  buf_last[0]      <= buf_last[1];
      if (push) buf_last[wr_idx] <= pend_last;
    end
  end

  // NOTE: buffer payload has no reset; count and the flags above decide
  // whether an entry is meaningful, and m_data is forced to 0 when empty.
  always_ff @(posedge clk) begin
    if (pop)  buf_data[0]      <= buf_data[1];
    if (push) buf_data[wr_idx] <= ram_qout;
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Testbench for ram_burst_reader: behavioural RAM with 1-cycle registered
// read, a scoreboard queue filled when a command is issued and drained by a
// stream monitor, and one task per scenario.

module tb_ram_burst_reader;

  localparam int DW    = 8;
  localparam int WORDS = 256;
  localparam int AW    = 8;
  localparam int LW    = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] ram_addr;
  logic          ram_wr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_qout;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic          done;

  ram_burst_reader #(.DW(DW), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .ram_addr  (ram_addr),
    .ram_wr    (ram_wr),
    .ram_din   (ram_din),
    .ram_qout  (ram_qout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, no enable.
  logic [DW-1:0] mem [WORDS];
  always @(posedge clk) ram_qout <= mem[ram_addr];

  int checks   = 0;
  int errors   = 0;
  int hs_count = 0;

  logic [DW:0] exp_q [$];   // {last, data}
  logic [DW:0] exp_w;
  logic [DW:0] prev_word;
  logic        prev_stall = 1'b0;

  // Stream monitor: scoreboard compare on every handshake, hold check on
  // every stalled word, write port must stay idle.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (ram_wr !== 1'b0 || ram_din !== '0) begin
        errors++;
        $display("FAIL ram_write_idle: ram_wr=%b ram_din=%h, required 0/00", ram_wr, ram_din);
      end
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || {m_last, m_data} !== prev_word) begin
          errors++;
          $display("FAIL stall_hold: valid=%b last/data=%h, required 1/%h", m_valid, {m_last, m_data}, prev_word);
        end
      end
      if (m_valid && m_ready) begin
        hs_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: last/data=%h, required no word", {m_last, m_data});
        end else begin
          exp_w = exp_q.pop_front();
          if ({m_last, m_data} !== exp_w) begin
            errors++;
            $display("FAIL stream_word: last/data=%h, required %h", {m_last, m_data}, exp_w);
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input logic [AW-1:0] a, input int len);
    logic [AW-1:0] ak;
    for (int k = 0; k < len; k++) begin
      ak = a + AW'(k);
      exp_q.push_back({(k == len - 1), mem[ak]});
    end
  endtask

  // Called just after a rising edge; returns just after the edge following
  // acceptance (cycle T+1) with cmd_valid dropped.
  task automatic start_cmd(input logic [AW-1:0] a, input logic [LW-1:0] len);
    bit ok;
    ok = 1'b0;
    cmd_addr  = a;
    cmd_len   = len;
    cmd_valid = 1'b1;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      else tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b, required 1 within 600 cycles", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  // Returns at the negedge of the cycle where done is high.
  task automatic wait_done(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
      else tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout: done=%b, required pulse within %0d cycles", done, bound);
    end
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_words_left: %0d words still expected, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({cmd_ready, m_valid, m_last, busy, done, ram_wr} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: rdy/val/last/busy/done/wr=%b, required 000000",
               {cmd_ready, m_valid, m_last, busy, done, ram_wr});
    end
    checks++;
    if ({ram_addr, ram_din, m_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h din=%h m_data=%h, required 00", ram_addr, ram_din, m_data);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b m_valid=%b, required 1/0", cmd_ready, m_valid);
    end
    tick();
  endtask

  task automatic test_basic();
    m_ready = 1'b1;
    push_expected(8'h10, 4);
    start_cmd(8'h10, 9'd4);
    @(negedge clk);  // cycle T+1: read issued, nothing visible yet
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b1 || ram_addr !== 8'h10) begin
      errors++;
      $display("FAIL basic_first_read: valid=%b busy=%b addr=%h, required 0/1/10", m_valid, busy, ram_addr);
    end
    for (int k = 2; k <= 5; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1) begin
        errors++;
        $display("FAIL basic_valid_T%0d: m_valid=%b, required 1", k, m_valid);
      end
    end
    tick();
    @(negedge clk);  // cycle T+6
    checks++;
    if ({done, busy, cmd_ready, m_valid} !== 4'b1010) begin
      errors++;
      $display("FAIL basic_done: done/busy/rdy/valid=%b, required 1010", {done, busy, cmd_ready, m_valid});
    end
    tick();
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b, required 0", done);
    end
    check_queue_empty("basic");
    tick();
  endtask

  task automatic test_wrap();
    logic [AW-1:0] want;
    m_ready = 1'b1;
    push_expected(8'hFE, 4);
    start_cmd(8'hFE, 9'd4);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      want = 8'hFE + AW'(k);
      checks++;
      if (ram_addr !== want) begin
        errors++;
        $display("FAIL wrap_addr_%0d: ram_addr=%h, required %h", k, ram_addr, want);
      end
    end
    tick();
    wait_done(20);
    check_queue_empty("wrap");
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] pat;
    bit         ok;
    bit         prev_last;
    int         base;
    pat       = 8'b0110_1001;  // cycle order 1,0,0,1,0,1,1,0
    base      = hs_count;
    ok        = 1'b0;
    prev_last = 1'b0;
    m_ready   = 1'b1;
    push_expected(8'h20, 8);
    start_cmd(8'h20, 9'd8);
    for (int i = 0; i < 100 && !ok; i++) begin
      m_ready = pat[i % 8];
      @(negedge clk);
      if (done) ok = 1'b1;
      else begin
        prev_last = m_valid && m_ready && m_last;
        tick();
      end
    end
    checks++;
    if (!ok || !prev_last) begin
      errors++;
      $display("FAIL bp_done_timing: done=%b last_hs_prev_cycle=%b, required 1/1", ok, prev_last);
    end
    checks++;
    if (hs_count - base != 8) begin
      errors++;
      $display("FAIL bp_word_count: %0d words, required 8", hs_count - base);
    end
    check_queue_empty("bp");
    tick();
    m_ready = 1'b1;
  endtask

  task automatic test_zero_len();
    int base;
    base    = hs_count;
    m_ready = 1'b1;
    start_cmd(8'h33, 9'd0);
    @(negedge clk);
    checks++;
    if ({done, busy, m_valid, cmd_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL zero_len_done: done/busy/valid/rdy=%b, required 1001", {done, busy, m_valid, cmd_ready});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({done, busy, m_valid, cmd_ready} !== 4'b0001 || hs_count != base) begin
      errors++;
      $display("FAIL zero_len_after: done/busy/valid/rdy=%b words=%0d, required 0001 and 0 words",
               {done, busy, m_valid, cmd_ready}, hs_count - base);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    int base;
    m_ready = 1'b1;
    push_expected(8'h30, 6);
    start_cmd(8'h30, 9'd6);  // now in T+1
    tick();                  // T+2: word 0
    tick();                  // T+3: word 1
    tick();                  // T+4: word 2, reset asserted
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== mem[8'h32]) begin
      errors++;
      $display("FAIL rst_mid_third_word: valid=%b data=%h, required 1/%h", m_valid, m_data, mem[8'h32]);
    end
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({m_valid, busy, done, cmd_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL rst_mid_state: valid/busy/done/rdy=%b, required 0001", {m_valid, busy, done, cmd_ready});
    end
    tick();
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_flushed: valid=%b done=%b, required 0/0", m_valid, done);
    end
    tick();
    base = hs_count;
    push_expected(8'h40, 2);
    start_cmd(8'h40, 9'd2);
    wait_done(20);
    checks++;
    if (hs_count - base != 2) begin
      errors++;
      $display("FAIL rst_mid_new_burst: %0d words, required 2", hs_count - base);
    end
    check_queue_empty("rst_mid");
    tick();
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_extra: m_valid=%b, required 0", m_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base;
    m_ready = 1'b1;
    push_expected(8'h50, 3);
    start_cmd(8'h50, 9'd3);
    // Second command presented immediately and held.
    cmd_addr  = 8'h60;
    cmd_len   = 9'd2;
    cmd_valid = 1'b1;
    push_expected(8'h60, 2);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
      else begin
        checks++;
        if (cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ready_while_busy: cmd_ready=%b, required 0", cmd_ready);
        end
        tick();
      end
    end
    checks++;
    if (!ok || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done_ready: done=%b cmd_ready=%b, required 1/1", ok, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_accept: busy=%b done=%b, required 1/0", busy, done);
    end
    tick();
    wait_done(20);
    check_queue_empty("b2b");
    tick();

    base = hs_count;
    push_expected(8'h80, 256);
    start_cmd(8'h80, 9'd256);
    wait_done(400);
    checks++;
    if (hs_count - base != 256) begin
      errors++;
      $display("FAIL full_len_count: %0d words, required 256", hs_count - base);
    end
    check_queue_empty("full_len");
    tick();
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = 8'(i * 37 + 11);
    for (int i = 0; i < 4; i++) mem[8'h10 + i] = 8'hA0 + 8'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_reset_mid_burst();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
